// File: rtl/bc_game_ctrl.sv
// Bulls-and-cows game sequencer: accepts secret/guess commits, strobes the datapath,
// scores each guess and tracks attempts until a win or a loss.
module bc_game_ctrl #(
  parameter int MAX_ATTEMPTS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save,
  input  logic [11:0] digits,
  input  logic [2:0]  bulls,
  input  logic [2:0]  cows,
  output logic        secret_load,
  output logic        guess_load,
  output logic [2:0]  last_bulls,
  output logic [2:0]  last_cows,
  output logic [3:0]  attempts,
  output logic [1:0]  disp_sel,
  output logic        err
);

  // state   | meaning
  // S_SECRET| waiting for a valid secret commit
  // S_GUESS | waiting for a valid guess commit
  // S_SCORE | comparator result valid, latch it and decide outcome
  // S_WIN   | game won, waiting for save to restart
  // S_LOSE  | attempts exhausted, waiting for save to restart
  typedef enum logic [2:0] {
    S_SECRET = 3'd0,
    S_GUESS  = 3'd1,
    S_SCORE  = 3'd2,
    S_WIN    = 3'd3,
    S_LOSE   = 3'd4
  } state_t;

  localparam logic [3:0] MAX_CNT  = 4'(MAX_ATTEMPTS);
  localparam logic [1:0] DISP_SEC = 2'd0;
  localparam logic [1:0] DISP_RES = 2'd1;
  localparam logic [1:0] DISP_WIN = 2'd2;
  localparam logic [1:0] DISP_LOS = 2'd3;

  state_t     state;
  logic       armed;
  logic       busy;
  logic       digits_ok;
  logic [2:0] dig_a, dig_b, dig_c, dig_d;
  logic [4:0] att_next;

  assign dig_a = digits[2:0];
  assign dig_b = digits[5:3];
  assign dig_c = digits[8:6];
  assign dig_d = digits[11:9];

  assign digits_ok = (dig_a != dig_b) && (dig_a != dig_c) && (dig_a != dig_d) &&
                     (dig_b != dig_c) && (dig_b != dig_d) && (dig_c != dig_d);

  // A strobe already in flight blocks new commits so pulses never run back to back.
  assign busy     = secret_load | guess_load | err;
  assign att_next = {1'b0, attempts} + 5'd1;

  // armed stays low for the first edge after reset release, so a save that
  // coincides with deassertion is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_SECRET;
      armed       <= 1'b0;
      secret_load <= 1'b0;
      guess_load  <= 1'b0;
      err         <= 1'b0;
      last_bulls  <= 3'd0;
      last_cows   <= 3'd0;
      attempts    <= 4'd0;
      disp_sel    <= DISP_SEC;
    end else begin
      armed       <= 1'b1;
      secret_load <= 1'b0;
      guess_load  <= 1'b0;
      err         <= 1'b0;
      case (state)
        S_SECRET: begin
          if (secret_load) begin
            state    <= S_GUESS;
            disp_sel <= DISP_RES;
          end else if (save && armed && !busy) begin
            if (digits_ok) begin
              secret_load <= 1'b1;
              attempts    <= 4'd0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_GUESS: begin
          if (guess_load) begin
            state <= S_SCORE;
          end else if (save && armed && !busy) begin
            if (digits_ok) guess_load <= 1'b1;
            else           err        <= 1'b1;
          end
        end
        S_SCORE: begin
          last_bulls <= bulls;
          last_cows  <= cows;
          if (attempts < MAX_CNT) attempts <= att_next[3:0];
          if (bulls == 3'd4) begin
            state    <= S_WIN;
            disp_sel <= DISP_WIN;
          end else if (att_next == {1'b0, MAX_CNT}) begin
            state    <= S_LOSE;
            disp_sel <= DISP_LOS;
          end else begin
            state    <= S_GUESS;
            disp_sel <= DISP_RES;
          end
        end
        S_WIN, S_LOSE: begin
          if (save && armed) begin
            state    <= S_SECRET;
            disp_sel <= DISP_SEC;
          end
        end
        default: begin
          state    <= S_SECRET;
          disp_sel <= DISP_SEC;
        end
      endcase
    end
  end

endmodule

// File: doc/bc_game_ctrl.md
BC_GAME_CTRL -- requirements
Module: bc_game_ctrl

Interface
REQ-001 Parameter: MAX_ATTEMPTS, default 10, number of guesses allowed before loss (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; asserting it immediately forces reset state.
REQ-004 save  input  1  one-cycle commit pulse, already synchronized and edge-detected upstream.
REQ-005 digits  input  12  four 3-bit digits: [2:0]=A, [5:3]=B, [8:6]=C, [11:9]=D.
REQ-006 bulls  input  3  comparator bull count (0..4), valid in SCORE state.
REQ-007 cows  input  3  comparator cow count (0..4), valid in SCORE state.
REQ-008 secret_load  output  1  one-cycle strobe; datapath latches digits as the secret.
REQ-009 guess_load  output  1  one-cycle strobe; datapath latches digits as the current guess.
REQ-010 last_bulls  output  3  registered bulls of the most recent scored guess.
REQ-011 last_cows  output  3  registered cows of the most recent scored guess.
REQ-012 attempts  output  4  number of guesses scored since the secret was set.
REQ-013 disp_sel  output  2  display mode: 0=prompt secret, 1=show result, 2=win, 3=lose.
REQ-014 err  output  1  one-cycle pulse on a rejected commit.

Function
REQ-015 States SHALL be SECRET, GUESS, SCORE, WIN, LOSE, held in a registered state machine.
REQ-016 A commit is valid only if A, B, C and D are pairwise distinct; otherwise it is invalid.
REQ-017 SECRET: save with valid digits -> secret_load=1 that cycle, attempts cleared, next state GUESS.
REQ-018 GUESS: save with valid digits -> guess_load=1 that cycle, next state SCORE.
REQ-019 SECRET or GUESS: save with invalid digits -> err=1 that cycle, no load strobe, state unchanged.
REQ-020 SCORE lasts exactly one cycle and ignores save: last_bulls<=bulls, last_cows<=cows, attempts<=attempts+1.
REQ-021 SCORE exit priority: bulls==4 -> WIN; else attempts+1==MAX_ATTEMPTS -> LOSE; else GUESS.
REQ-022 A win on the final allowed attempt SHALL go to WIN, not LOSE.
REQ-023 WIN/LOSE: save (digit validity irrelevant, err stays 0) -> next state SECRET; last_bulls, last_cows and attempts are held until the next secret_load.
REQ-024 attempts SHALL never exceed MAX_ATTEMPTS and SHALL not wrap.
REQ-025 secret_load, guess_load and err are registered and mutually exclusive, at most one high per cycle, and never high two cycles in a row.
REQ-026 disp_sel is decoded from state: SECRET=0, GUESS/SCORE=1, WIN=2, LOSE=3.
REQ-027 Bulls/cows values >4 in SCORE SHALL be latched unmodified; only bulls==4 means win.
REQ-028 Latency: save sampled high in cycle n -> strobe high in cycle n+1; scoring in cycle n+2; new disp_sel in cycle n+3.

Reset
REQ-029 rst asserted: state=SECRET, attempts=0, last_bulls=0, last_cows=0, all strobes and err=0, disp_sel=0, asynchronously.
REQ-030 Reset mid-operation (any state, including SCORE) SHALL abandon the game with no strobe emitted; the first save after release is treated as a secret commit.
REQ-031 A save coincident with rst deassertion edge SHALL be ignored.

Verification
REQ-032 Reset, save digits A..D=1,2,3,4 -> secret_load pulse one cycle, disp_sel 0->1, attempts=0.
REQ-033 In SECRET, save digits 1,1,3,4 -> err pulse, no secret_load, disp_sel stays 0.
REQ-034 In GUESS, save 4,3,2,1 with bulls=0, cows=4 -> guess_load pulse, then last_cows=4, attempts=1, state GUESS.
REQ-035 MAX_ATTEMPTS=3, three scored guesses with bulls=2 -> attempts=3, disp_sel=3; save -> disp_sel=0; next valid secret -> attempts=0.
REQ-036 MAX_ATTEMPTS=3, third guess scored with bulls=4 -> disp_sel=2, not 3.
REQ-037 Assert rst during SCORE cycle -> no change to last_bulls; all outputs at reset values immediately, before next clock edge.
